// File: rtl/tdm_demux2.sv
// Receive side of the 2:1 TDM link: locks to sof framing, steers slot 0/1 beats
// to held output registers, pulses on updates and drops lock after repeated framing errors.
module tdm_demux2 #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_ERR = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          sof,
  output logic [DW-1:0] y0,
  output logic [DW-1:0] y1,
  output logic          y0_valid,
  output logic          y1_valid,
  output logic          pair_valid,
  output logic          locked,
  output logic          sync_err,
  output logic [3:0]    err_cnt
);

  localparam int unsigned EW = 4;
  localparam logic [EW-1:0] ERR_SAT = '1;
  localparam logic [EW-1:0] ERR_LIM = EW'(MAX_ERR);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP1 = 2'd1,
    EXP0 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] y0_q, y0_d;
  logic [DW-1:0] y1_q, y1_d;
  logic          y0_valid_q, y0_valid_d;
  logic          y1_valid_q, y1_valid_d;
  logic          pair_valid_q, pair_valid_d;
  logic          locked_q, locked_d;
  logic          sync_err_q, sync_err_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [EW-1:0] err_inc;
  logic          lose_lock;

  // Saturating error increment and the lock-loss threshold it would hit
  always_comb begin
    err_inc   = (err_cnt_q == ERR_SAT) ? ERR_SAT : EW'(err_cnt_q + EW'(1));
    lose_lock = (err_inc == ERR_LIM);
  end

  // Next-state and output decode; an idle cycle holds everything and clears pulses
  always_comb begin
    state_d      = state_q;
    y0_d         = y0_q;
    y1_d         = y1_q;
    y0_valid_d   = 1'b0;
    y1_valid_d   = 1'b0;
    pair_valid_d = 1'b0;
    locked_d     = locked_q;
    sync_err_d   = 1'b0;
    err_cnt_d    = err_cnt_q;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sof) begin
            y0_d       = din;
            y0_valid_d = 1'b1;
            locked_d   = 1'b1;
            err_cnt_d  = '0;
            state_d    = EXP1;
          end
        end
        EXP1: begin
          if (!sof) begin
            y1_d         = din;
            y1_valid_d   = 1'b1;
            pair_valid_d = 1'b1;
            err_cnt_d    = '0;
            state_d      = EXP0;
          end else begin
            sync_err_d = 1'b1;
            if (lose_lock) begin
              locked_d  = 1'b0;
              err_cnt_d = '0;
              state_d   = HUNT;
            end else begin
              // Missing slot 1: resynchronise on this sof beat as a fresh slot 0
              err_cnt_d  = err_inc;
              y0_d       = din;
              y0_valid_d = 1'b1;
            end
          end
        end
        EXP0: begin
          if (sof) begin
            y0_d       = din;
            y0_valid_d = 1'b1;
            state_d    = EXP1;
          end else begin
            sync_err_d = 1'b1;
            if (lose_lock) begin
              locked_d  = 1'b0;
              err_cnt_d = '0;
              state_d   = HUNT;
            end else begin
              err_cnt_d = err_inc;
            end
          end
        end
        default: begin
          locked_d  = 1'b0;
          err_cnt_d = '0;
          state_d   = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      y0_q         <= '0;
      y1_q         <= '0;
      y0_valid_q   <= 1'b0;
      y1_valid_q   <= 1'b0;
      pair_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      y0_q         <= y0_d;
      y1_q         <= y1_d;
      y0_valid_q   <= y0_valid_d;
      y1_valid_q   <= y1_valid_d;
      pair_valid_q <= pair_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign y0         = y0_q;
  assign y1         = y1_q;
  assign y0_valid   = y0_valid_q;
  assign y1_valid   = y1_valid_q;
  assign pair_valid = pair_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
